// File: rtl/frv_mem_pkg.sv
// ============================================================================
// Module      : frv_mem_pkg
// Description : Shared types and constants for the FRV memory responder.
//               Holds the response-entry record and the LFSR seed used by
//               the optional random-stall mode.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package frv_mem_pkg;

  // One queued response: read data plus out-of-range flag.
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } resp_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

endpackage

`default_nettype wire

// File: rtl/frv_mem_resp_fifo.sv
// ============================================================================
// Module      : frv_mem_resp_fifo
// Description : In-order response queue. Circular buffer of resp_t with a
//               per-entry age counter; the head is ready once its age has
//               reached LATENCY. Push/pop may coincide.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module frv_mem_resp_fifo
  import frv_mem_pkg::*;
#(
  parameter int ENTRIES = 2,
  parameter int LATENCY = 1,
  localparam int CW     = $clog2(ENTRIES + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  resp_t         push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          head_ready,
  output resp_t         head_data
);

  localparam int         PW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [3:0] LAT_AGE = 4'(LATENCY);
  localparam logic [3:0] AGE_NEW = 4'd1;  // already one cycle old at the first edge

  resp_t         slots   [ENTRIES];
  logic [3:0]    age     [ENTRIES];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_ready = (count != '0) && (age[rd_ptr] >= LAT_AGE);
  assign head_data  = slots[rd_ptr];
  assign do_pop     = pop && head_ready;

  // Payload storage; contents need no reset because count gates validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and saturating ages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        age[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      for (int i = 0; i < ENTRIES; i++) begin
        if (push && (wr_ptr == PW'(i))) begin
          age[i] <= AGE_NEW;
        end else if (age[i] < LAT_AGE) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/frv_mem_responder.sv
// ============================================================================
// Module      : frv_mem_responder
// Description : Memory-side responder for the FRV req/gnt + recv/ack
//               protocol. Word-organised storage, fixed minimum response
//               latency and a bounded in-order response queue.
//               Optional macro FRV_MEM_RESPONDER_RAND_STALL_EN adds an
//               LFSR that randomly refuses grants for stress testing.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module frv_mem_responder
  import frv_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OUTSTANDING + 1);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   word_addr;
  logic [AW-1:0] idx;
  logic          oor;
  logic          stall;
  logic [CW-1:0] count;
  logic          head_ready;
  resp_t         head_data;
  resp_t         push_data;

  // Byte offset bits are dropped; anything above the array is out of range.
  assign word_addr = mem_addr >> 2;
  assign idx       = word_addr[AW-1:0];
  assign oor       = |word_addr[31:AW];

`ifdef FRV_MEM_RESPONDER_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) that drives pseudo-random grant stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Grant uses the registered occupancy only, so a same-cycle pop never frees a slot.
  assign mem_gnt = mem_req && !rst_i && !stall && (count < CW'(OUTSTANDING));

  // Byte-lane writes on grant; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (mem_gnt && mem_wen && !oor) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (mem_strb[b]) begin
          mem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign push_data.rdata = (mem_wen || oor) ? 32'h0 : mem[idx];
  assign push_data.error = oor;

  frv_mem_resp_fifo #(
    .ENTRIES (OUTSTANDING),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (mem_gnt),
    .push_data  (push_data),
    .pop        (mem_ack),
    .count      (count),
    .head_ready (head_ready),
    .head_data  (head_data)
  );

  assign mem_recv  = head_ready;
  assign mem_rdata = head_ready ? head_data.rdata : 32'h0;
  assign mem_error = head_ready ? head_data.error : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_frv_mem_responder.sv
// ============================================================================
// Module      : tb_frv_mem_responder
// Description : Self-checking bench for frv_mem_responder. A transaction-level
//               reference (byte-addressed word array plus a queue of pending
//               responses stamped with their grant cycle) predicts gnt, recv,
//               rdata and error every cycle; directed scenarios also check
//               captured responses against literal values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_frv_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int OUTS  = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_wen = 1'b0;
  logic [3:0]  mem_strb = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_addr = 32'h0;
  logic        mem_ack = 1'b0;
  logic        mem_gnt;
  logic        mem_recv;
  logic        mem_error;
  logic [31:0] mem_rdata;

  frv_mem_responder #(
    .DEPTH       (DEPTH),
    .LATENCY     (LAT),
    .OUTSTANDING (OUTS)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_recv  (mem_recv),
    .mem_ack   (mem_ack),
    .mem_error (mem_error),
    .mem_rdata (mem_rdata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mm [DEPTH];
  logic [32:0] log_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        dut_gnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, predict and compare, then advance the reference.
  task automatic step(input logic req, input logic wen, input logic [3:0] strb,
                      input logic [31:0] wdata, input logic [31:0] addr,
                      input logic ack, output logic granted);
    ent_t        e;
    logic        eg;
    logic        er;
    logic [31:0] erd;
    logic        ee;
    logic        oor;
    int          wi;
    mem_req   = req;
    mem_wen   = wen;
    mem_strb  = strb;
    mem_wdata = wdata;
    mem_addr  = addr;
    mem_ack   = ack;
    @(negedge clk_i);
    eg  = req && (q.size() < OUTS);
    er  = (q.size() > 0) && (cyc >= q[0].gcyc + LAT);
    erd = er ? q[0].rdata : 32'h0;
    ee  = er ? q[0].err : 1'b0;
    check("gnt",   64'(mem_gnt),   64'(eg));
    check("recv",  64'(mem_recv),  64'(er));
    check("rdata", 64'(mem_rdata), 64'(erd));
    check("error", 64'(mem_error), 64'(ee));
    if (mem_recv && ack) log_q.push_back({mem_error, mem_rdata});
    dut_gnt = mem_gnt;
    granted = eg;
    if (er && ack) q.delete(0);
    if (eg) begin
      oor    = (addr >> 2) >= DEPTH;
      wi     = int'((addr >> 2) % DEPTH);
      e.err  = oor;
      e.rdata = (wen || oor) ? 32'h0 : mm[wi];
      e.gcyc = cyc;
      q.push_back(e);
      if (wen && !oor) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) mm[wi][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  // Hold a request until the reference grants it, within a bounded number of cycles.
  task automatic issue(input logic wen, input logic [3:0] strb, input logic [31:0] wdata,
                       input logic [31:0] addr, input logic ack);
    logic g;
    g = 1'b0;
    for (int t = 0; t < 20 && !g; t++) begin
      step(1'b1, wen, strb, wdata, addr, ack, g);
    end
    if (!g) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, input logic ack);
    logic g;
    for (int t = 0; t < n; t++) begin
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ack, g);
    end
  endtask

  int   n_gr;
  int   dut_grant_k[$];
  logic g;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with a request pending that must not be granted.
    mem_req = 1'b1;
    #1;
    check("rst_gnt",   64'(mem_gnt),   64'd0);
    check("rst_recv",  64'(mem_recv),  64'd0);
    check("rst_rdata", 64'(mem_rdata), 64'd0);
    check("rst_error", 64'(mem_error), 64'd0);
    mem_req = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Fill a small window of words with known values.
    for (int k = 0; k < 16; k++) begin
      issue(1'b1, 4'hF, 32'h5A5A0000 | k, 32'(k * 4), 1'b1);
    end
    idle(4, 1'b1);

    // Single write then read.
    log_q.delete();
    issue(1'b1, 4'hF, 32'hDEADBEEF, 32'h10, 1'b1);
    issue(1'b0, 4'h0, 32'h0, 32'h10, 1'b1);
    idle(4, 1'b1);
    check("wr_rd_count", 64'(log_q.size()), 64'd2);
    check("wr_resp",     64'(log_q[0]), {31'h0, 1'b0, 32'h0});
    check("rd_resp",     64'(log_q[1]), {31'h0, 1'b0, 32'hDEADBEEF});

    // Byte strobes.
    log_q.delete();
    issue(1'b1, 4'hF,    32'h11223344, 32'h20, 1'b1);
    issue(1'b1, 4'b0101, 32'hAABBCCDD, 32'h20, 1'b1);
    issue(1'b0, 4'h0,    32'h0,        32'h20, 1'b1);
    idle(4, 1'b1);
    check("strb_count", 64'(log_q.size()), 64'd3);
    check("strb_rd",    64'(log_q[2]), {31'h0, 1'b0, 32'h11BB33DD});

    // Back-pressure: four reads against a three-deep queue, ack low for six cycles.
    log_q.delete();
    n_gr = 0;
    for (int k = 0; k < 15; k++) begin
      step(n_gr < 4, 1'b0, 4'h0, 32'h0, (n_gr % 2 == 1) ? 32'h20 : 32'h10, k >= 6, g);
      if (dut_gnt) dut_grant_k.push_back(k);
      if (g) n_gr++;
    end
    idle(4, 1'b1);
    check("bp_grants",   64'(dut_grant_k.size()), 64'd4);
    check("bp_4th_gnt",  64'(dut_grant_k[3]),     64'd7);
    check("bp_count",    64'(log_q.size()),       64'd4);
    check("bp_order0",   64'(log_q[0]), {31'h0, 1'b0, 32'hDEADBEEF});
    check("bp_order1",   64'(log_q[1]), {31'h0, 1'b0, 32'h11BB33DD});
    check("bp_order2",   64'(log_q[2]), {31'h0, 1'b0, 32'hDEADBEEF});
    check("bp_order3",   64'(log_q[3]), {31'h0, 1'b0, 32'h11BB33DD});

    // Out-of-range read and write; word 0 (same low index) must be untouched.
    log_q.delete();
    issue(1'b0, 4'h0, 32'h0,        32'h0000_1000, 1'b1);
    issue(1'b1, 4'hF, 32'hFFFFFFFF, 32'h0000_1000, 1'b1);
    issue(1'b0, 4'h0, 32'h0,        32'h0000_0000, 1'b1);
    idle(4, 1'b1);
    check("oor_count", 64'(log_q.size()), 64'd3);
    check("oor_rd",    64'(log_q[0]), {31'h0, 1'b1, 32'h0});
    check("oor_wr",    64'(log_q[1]), {31'h0, 1'b1, 32'h0});
    check("oor_alias", 64'(log_q[2]), {31'h0, 1'b0, 32'h5A5A0000});

    // Reset with two responses queued and visible.
    issue(1'b0, 4'h0, 32'h0, 32'h10, 1'b0);
    issue(1'b0, 4'h0, 32'h0, 32'h20, 1'b0);
    idle(3, 1'b0);
    mem_req  = 1'b1;
    mem_wen  = 1'b0;
    mem_addr = 32'h10;
    rst_i    = 1'b1;
    #1;
    check("mid_rst_gnt",   64'(mem_gnt),   64'd0);
    check("mid_rst_recv",  64'(mem_recv),  64'd0);
    check("mid_rst_rdata", 64'(mem_rdata), 64'd0);
    check("mid_rst_error", 64'(mem_error), 64'd0);
    q.delete();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    log_q.delete();
    issue(1'b0, 4'h0, 32'h0, 32'h10, 1'b1);
    idle(5, 1'b1);
    check("post_rst_count", 64'(log_q.size()), 64'd1);
    check("post_rst_rd",    64'(log_q[0]), {31'h0, 1'b0, 32'hDEADBEEF});

    // Randomised traffic over the known window plus occasional out-of-range hits.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
      else a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), $urandom, a,
           $urandom_range(0, 3) != 0, g);
    end
    idle(8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frv_mem_responder.md
# frv_mem_responder

Memory-side responder for the FRV core memory protocol (req/gnt request channel, recv/ack response channel). It sits at the far end of the core's instruction or data port and serves as a bench memory model and as on-chip scratch RAM. It has word-organised storage, a configurable response latency and a bounded in-order response queue. It honours core back-pressure on `mem_ack` and never drops or reorders responses.

## Interface
- `DEPTH`, 1024: storage size in 32-bit words; power of two. `AW = $clog2(DEPTH)`.
- `LATENCY`, 1: cycles from grant to earliest `mem_recv`; legal range 1..15.
- `OUTSTANDING`, 2: response queue capacity, counting both granted-not-visible and visible-not-acked responses; range 1..8.

- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `mem_req` in 1: request valid.
- `mem_wen` in 1: write enable.
- `mem_strb` in 4: byte write strobe.
- `mem_wdata` in 32: write data.
- `mem_addr` in 32: byte address; bits [1:0] ignored.
- `mem_gnt` out 1: request accepted this cycle.
- `mem_recv` out 1: response valid.
- `mem_ack` in 1: core accepts response.
- `mem_error` out 1: response error flag (out-of-range access).
- `mem_rdata` out 32: response read data.

## Operation
- **Grant:** `mem_gnt = mem_req && !rst_i && (count < OUTSTANDING)`.
  - There is no combinational path from `mem_ack` to `mem_gnt`. With a full queue and a pop in the same cycle, the grant is still refused.
- **Access at grant:** the array is accessed in the grant cycle.
  - Index = `mem_addr[AW+1:2]`.
  - Out of range when `mem_addr[31:AW+2] != 0`. Such an access performs no write, has rdata 0 and error 1.
  - Write: byte lanes with their strobe set are updated; the response has rdata 0 and error 0.
  - Read: current word; a write granted in the preceding cycle is visible.
- **Queue entry:** `{rdata, error, age}`, pushed at grant with age 0.
  - Every entry's age increments each cycle, saturating at `LATENCY`.
- **Response:** `mem_recv = head_valid && head_age >= LATENCY`.
  - `mem_rdata` and `mem_error` come from the head entry.
  - They are 0 when `mem_recv` is low.
- **Pop:** `mem_recv && mem_ack`. Push and pop in the same cycle leave `count` unchanged.
- **Back-pressure:** if `mem_ack` is low, the head stays valid and its data stays stable. Later entries keep aging and may already be ready.
- **Ignored ack:** `mem_ack` without `mem_recv` has no effect.
- **Reset:** asynchronous; queue emptied, counts and ages 0, LFSR reseeded.
  - Outputs during and after reset: `mem_gnt=0`, `mem_recv=0`, `mem_error=0`, `mem_rdata=0`.
  - Responses in flight are discarded.
  - The array is not reset.

## Timing
- Request granted in cycle T → `mem_recv` no earlier than T+LATENCY. With LATENCY=1 and `mem_ack` tied high, a new request is granted and completed every cycle.
- Back-to-back grants produce back-to-back `mem_recv` cycles in grant order while `mem_ack` is held high.
- Once `count` reaches OUTSTANDING, `mem_gnt` is 0. It can return the cycle after the pop.
- Reset deassertion: the first grant is possible in the first cycle with `rst_i` low.

## Configuration
- `FRV_MEM_RESPONDER_RAND_STALL_EN`
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle. `mem_gnt` is additionally forced to 0 when `lfsr[1:0]==2'b00`. Used for verification stress.
  - Undefined: no LFSR; grant depends only on `mem_req` and queue occupancy.

## Structure
- Package `frv_mem_pkg`:
  - `resp_t` struct `{logic [31:0] rdata; logic error;}`
  - `WORD_BYTES=4`
  - LFSR seed constant
- Sub-module `frv_mem_resp_fifo`:
  - Circular buffer of `resp_t` plus per-entry age, with push/pop/count and head-ready output.
- The top level holds the array, address decode, grant logic and optional LFSR.

## Test plan
- **Single write/read**, LATENCY=1: write 32'hDEADBEEF to 0x10, strb 4'hF, ack high, then read 0x10 → recv one cycle after each grant; read rdata 32'hDEADBEEF, error 0.
- **Byte strobes:** write 32'h11223344 to 0x20 with strb 4'hF, then 32'hAABBCCDD with strb 4'b0101 → read returns 32'h11BB33DD.
- **Back-pressure**, OUTSTANDING=2, ack held low: issue 3 reads → first two granted, third held with `gnt=0`. Raise ack → responses arrive in order; third is granted the cycle after the first pop.
- **Latency**, LATENCY=4: a read granted at cycle 10 gives recv first high at cycle 14; rdata is stable while ack is low.
- **Out of range**, DEPTH=1024: read 0x0000_1000 → recv with error 1, rdata 0. A write to the same address leaves the array unchanged.
- **Reset mid-flight:** assert `rst_i` with 2 entries queued → recv and gnt go 0 immediately. After release, a new read returns correct data with no stale response.
